// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer
// Memory-access stage between the EX/MEM pipeline register and a byte-wide data memory.
// Byte, half and word loads and stores are split into sequential single-byte memory cycles,
// little-endian. Load data is assembled and sign/zero extended. The pipeline is stalled
// until the access completes.
//
// Optional feature macro: MEM_SEQ_ALIGN_CHECK_EN
//   defined   : misaligned half/word requests skip the memory and complete with misalign_err=1
//   undefined : misalign_err is tied 0 and misaligned requests run byte-wise with wrap
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   req_valid           request from EX/MEM, held stable while stall=1
//   req_write           1=store, 0=load
//   req_size            00 byte, 01 half, 10/11 word
//   req_sign            load sign-extend (1) / zero-extend (0)
//   req_addr            byte address of the lowest byte
//   req_wdata           store data, byte i goes to addr+i
//   mem_addr            byte address to data memory
//   mem_wdata           byte to write
//   mem_write/mem_read  memory strobes, only asserted in the access state
//   mem_rdata           combinational read data from data memory
//   stall               hold pipeline
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           extended load result, held until the next load completes
//   misalign_err        valid with rsp_valid
module mem_byte_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [7:0]        mem_rdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic              sign_q;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic [1:0]        last_cnt;
  logic              last_byte;
  logic [ADDR_BITS-1:0] low_addr;
  logic [31:0]       assembled;
  logic [31:0]       extended;
  logic              misaligned;

  assign accept = (state_q == StIdle) && req_valid;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  logic misal_q, misal_d;

  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  always_comb begin
    misal_d = misal_q;
    if (accept) begin
      misal_d = misaligned;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misal_q <= 1'b0;
    end else begin
      misal_q <= misal_d;
    end
  end

  assign misalign_err = (state_q == StDone) && misal_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Index of the final byte: N-1 for N = 1/2/4.
  always_comb begin
    last_cnt = 2'd3;
    unique case (size_q)
      2'b00:   last_cnt = 2'd0;
      2'b01:   last_cnt = 2'd1;
      default: last_cnt = 2'd3;
    endcase
  end

  assign last_byte = (cnt_q == last_cnt);

  // Only the low ADDR_BITS increment; carries out of that field are dropped so the
  // access wraps inside the decoded window while the upper address bits stay put.
  assign low_addr = addr_q[ADDR_BITS-1:0] + ADDR_BITS'(cnt_q);

  // Load buffer with the byte arriving this cycle already merged in, so the final
  // byte can go straight into the response register.
  always_comb begin
    assembled = rbuf_q;
    assembled[{cnt_q, 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    extended = assembled;
    unique case (size_q)
      2'b00:   extended = {{24{sign_q & assembled[7]}}, assembled[7:0]};
      2'b01:   extended = {{16{sign_q & assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  // Next state and load datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rbuf_d      = rbuf_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 2'd0;
        if (req_valid) begin
          state_d = misaligned ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (!write_q) begin
          rbuf_d = assembled;
        end
        if (last_byte) begin
          state_d = StDone;
          cnt_d   = 2'd0;
          if (!write_q) begin
            rsp_rdata_d = extended;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDone: begin
        // A request still asserted here is the one just served; it is not re-sampled.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      rbuf_q      <= 32'd0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rbuf_q      <= rbuf_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      sign_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
      write_q <= req_write;
      sign_q  <= req_sign;
    end
  end

  // Memory-side outputs decode from state so an asynchronous reset drops them immediately.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = 8'h00;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (state_q == StAccess) begin
      mem_addr  = {addr_q[ADDR_W-1:ADDR_BITS], low_addr};
      mem_write = write_q;
      mem_read  = !write_q;
      if (write_q) begin
        mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
      end
    end
  end

  assign stall     = accept || (state_q == StAccess);
  assign rsp_valid = (state_q == StDone);
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Scoreboard bench for mem_byte_sequencer: requests push their hand-computed response into a
// queue, a monitor pops and compares on every rsp_valid. A 16x8 memory model sits on the bus.
module tb_mem_byte_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  mem_rdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;

  int checks;
  int failures;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wd;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_log[$];
  exp_t mon_e;

  logic [7:0] tbmem [16];
  logic       poke_en;
  logic [3:0] poke_a;
  logic [7:0] poke_d;

  mem_byte_sequencer #(
    .ADDR_W   (32),
    .ADDR_BITS(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_sign    (req_sign),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = tbmem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (poke_en) tbmem[poke_a] <= poke_d;
    else if (mem_write) tbmem[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic chk_acc(input int idx, input logic [31:0] a, input logic wr, input logic [7:0] wd);
    if (idx >= acc_log.size()) begin
      chk($sformatf("acc%0d_present", idx), acc_log.size(), idx + 1);
    end else begin
      chk($sformatf("acc%0d_addr", idx), acc_log[idx].addr, a);
      chk($sformatf("acc%0d_write", idx), {31'b0, acc_log[idx].wr}, {31'b0, wr});
      if (wr) chk($sformatf("acc%0d_wdata", idx), {24'b0, acc_log[idx].wd}, {24'b0, wd});
    end
  endtask

  // Issue one request and watch it to completion; exp_n is the number of memory cycles.
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_mis,
                         input int exp_n, input logic hold);
    int stall_cnt;
    int rsp_at;
    @(negedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_sign  = sg;
    req_addr  = a;
    req_wdata = wd;
    acc_log.delete();
    exp_q.push_back('{rdata: exp_rd, mis: exp_mis});
    #1;
    stall_cnt = (stall === 1'b1) ? 1 : 0;
    rsp_at    = -1;
    for (int i = 0; i < 12 && rsp_at < 0; i++) begin
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      if (mem_read === 1'b1 || mem_write === 1'b1)
        acc_log.push_back('{addr: mem_addr, wr: mem_write, wd: mem_wdata});
      if (rsp_valid === 1'b1) begin
        rsp_at = i;
        chk("done_mem_addr", mem_addr, 32'h0);
        chk("done_strobes", {30'b0, mem_read, mem_write}, 32'h0);
        chk("done_mem_wdata", {24'b0, mem_wdata}, 32'h0);
      end
    end
    chk("rsp_cycle", rsp_at, exp_n);
    chk("stall_cycles", stall_cnt, exp_n + 1);
    if (!hold) req_valid = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, mon_e.mis});
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    poke_en   = 1'b0;
    poke_a    = 4'h0;
    poke_d    = 8'h00;
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    // Reset state, with stall following req_valid.
    #2;
    chk("rst_stall_follows_req", {31'b0, stall}, 32'h1);
    req_valid = 1'b0;
    #1;
    chk("rst_stall_idle", {31'b0, stall}, 32'h0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'h0);
    chk("rst_rsp", {30'b0, rsp_valid, misalign_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);

    for (int i = 0; i < 16; i++) poke(4'(i), 8'h00);
    poke(4'h0, 8'h81);
    poke(4'h2, 8'h34);
    poke(4'h3, 8'h9A);
    poke(4'hA, 8'hAA);
    poke(4'hB, 8'hBB);
    poke(4'hE, 8'h0F);
    poke(4'hF, 8'h10);
    @(negedge clk);
    reset = 1'b1;

    // Word store, 4 byte cycles, stall 5, rsp_rdata untouched.
    run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 4, 1'b0);
    chk_acc(0, 32'h4, 1'b1, 8'hEF);
    chk_acc(1, 32'h5, 1'b1, 8'hBE);
    chk_acc(2, 32'h6, 1'b1, 8'hAD);
    chk_acc(3, 32'h7, 1'b1, 8'hDE);
    chk("mem7_written", {24'b0, tbmem[7]}, 32'hDE);

    // Byte loads, signed and unsigned.
    run_req(1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'hFFFFFF81, 1'b0, 1, 1'b0);
    chk_acc(0, 32'h0, 1'b0, 8'h00);
    run_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h00000081, 1'b0, 1, 1'b0);

    // Signed half load.
    run_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'hFFFF9A34, 1'b0, 2, 1'b0);

    // Byte store keeps the previous load result.
    run_req(1'b1, 2'b00, 1'b0, 32'hC, 32'hAAAAAA55, 32'hFFFF9A34, 1'b0, 1, 1'b0);
    chk_acc(0, 32'hC, 1'b1, 8'h55);
    chk("memC_written", {24'b0, tbmem[12]}, 32'h55);

    // Unsigned half at the top of the window.
    run_req(1'b0, 2'b01, 1'b0, 32'hE, 32'h0, 32'h0000100F, 1'b0, 2, 1'b0);
    chk_acc(0, 32'hE, 1'b0, 8'h00);
    chk_acc(1, 32'hF, 1'b0, 8'h00);

    // Word load reads back the earlier store.
    run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 4, 1'b0);

    // Misaligned word that wraps, upper address bits held.
    poke(4'h0, 8'h01);
    poke(4'h1, 8'h02);
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    run_req(1'b0, 2'b11, 1'b0, 32'hFE, 32'h0, 32'hDEADBEEF, 1'b1, 0, 1'b0);
    chk("misaligned_no_access", acc_log.size(), 0);
`else
    run_req(1'b0, 2'b11, 1'b0, 32'hFE, 32'h0, 32'h0201100F, 1'b0, 4, 1'b0);
    chk_acc(0, 32'hFE, 1'b0, 8'h00);
    chk_acc(1, 32'hFF, 1'b0, 8'h00);
    chk_acc(2, 32'hF0, 1'b0, 8'h00);
    chk_acc(3, 32'hF1, 1'b0, 8'h00);
`endif

    // Reset in the third byte cycle of a word store.
    @(negedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b10;
    req_sign  = 1'b0;
    req_addr  = 32'h8;
    req_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_write", {31'b0, mem_write}, 32'h1);
    reset = 1'b0;
    #1;
    chk("reset_drops_write", {31'b0, mem_write}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_stall_follows_req", {31'b0, stall}, 32'h1);
    chk("reset_no_rsp", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    req_valid = 1'b0;
    #1;
    chk("reset_stall_idle", {31'b0, stall}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mem8_written", {24'b0, tbmem[8]}, 32'h44);
    chk("mem9_written", {24'b0, tbmem[9]}, 32'h33);
    chk("memA_kept", {24'b0, tbmem[10]}, 32'hAA);
    chk("memB_kept", {24'b0, tbmem[11]}, 32'hBB);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {29'b0, stall, mem_read, mem_write}, 32'h0);

    // Request held through DONE: one read, then re-served only from the next IDLE.
    run_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'h0000009A, 1'b0, 1, 1'b1);
    chk("held_req_reads", acc_log.size(), 1);
    run_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'h0000009A, 1'b0, 1, 1'b0);
    chk("second_req_reads", acc_log.size(), 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
